byte_striping_n: RTL
====================

Name: byte_striping_n

Overview:
Parametrised successor to the two-lane byte striper. Distributes a serial stream of DATA_W-bit words round-robin across LANES output lanes in the clk_2f domain. Adds a per-lane enable mask for degraded-link operation, a realign request to restart striping at the lowest enabled lane, and an error flag for words that have no lane to go to. Sits between the serial-side data source and the per-lane downstream logic (lane FIFOs, serializers).

Parameters:
DATA_W, 8, width of one data word and of each lane.
LANES, 4, number of output lanes; legal range 2..8. Pointer width is derived internally as clog2(LANES).

Ports:
clk_2f  input  1  single clock; all logic is rising-edge.
reset  input  1  synchronous, active-high; dominates all other inputs.
valid_in  input  1  data_in carries a word this cycle.
data_in  input  DATA_W  input word.
lane_en  input  LANES  bit i=1 enables lane i; treated as quasi-static but sampled every cycle.
realign  input  1  single-cycle request; the next word goes to the lowest enabled lane.
lane_data  output  LANES*DATA_W  flattened lane words; lane i occupies bits [i*DATA_W +: DATA_W]; registered.
lane_valid  output  LANES  bit i=1 means lane i carries a new word this cycle; registered.
err_no_lane  output  1  one-cycle pulse: a word was dropped because lane_en was all zero.

Behaviour:
- Reset (sampled on the clk_2f edge): lane_data=0, lane_valid=0, err_no_lane=0, internal pointer ptr=0. Output registers change only on the clock edge.
- Latency: exactly 1 cycle from valid_in to lane_valid. There is no backpressure. At most one lane_valid bit is high in any cycle.
- Target lane selection, with valid_in=1 at edge k:
  - Base index is 0 if realign=1, otherwise ptr.
  - Target = first enabled lane at or above the base index, wrapping ascending modulo LANES.
  - The selection uses the lane_en value at edge k.
- Outputs after edge k with a target: lane_data[target]=data_in, lane_valid=one-hot(target). Other lanes' lane_data hold their previous values. ptr = (target+1) mod LANES, i.e. the raw successor, not pre-skipped.
- valid_in=0: lane_valid=0; lane_data and err_no_lane are unchanged except err_no_lane clears to 0; ptr holds.
- realign=1 with valid_in=0: ptr=0. The next word goes to the lowest enabled lane.
- realign=1 with valid_in=1: the word goes to the lowest enabled lane; ptr = that lane + 1 (mod LANES).
- lane_en all zero with valid_in=1:
  - The word is dropped and lane_valid=0.
  - err_no_lane=1 for one cycle, then 0 unless repeated.
  - ptr holds, or becomes 0 if realign=1.
- lane_en change mid-stream: takes effect at the next edge. A pointer parked on a now-disabled lane skips forward to the next enabled lane; no word is lost while any lane is enabled.
- Single enabled lane: every word goes to that lane, back-to-back.
- Wrap: after lane LANES-1, ptr returns to 0.
- Reset mid-stream: words in flight are discarded. The first word after reset deasserts goes to the lowest enabled lane at or above 0.

Test Plan:
- Basic striping (LANES=4, DATA_W=8, lane_en=4'b1111): reset 2 cycles, then 0x10..0x17 back-to-back → one cycle later lanes 0,1,2,3,0,1,2,3 receive 0x10..0x17 in order. lane_valid sequence is 0001,0010,0100,1000 repeating. Lane 0 ends holding 0x14.
- Degraded mask (lane_en=4'b1010): send 0xA0,0xA1,0xA2 → lane1=0xA0, lane3=0xA1, lane1=0xA2. lane_valid sequence is 0010,1000,0010. Lanes 0 and 2 never valid.
- Gaps (lane_en=4'b1111): send 0x01,0x02, hold valid_in=0 for 3 cycles, then send 0x03 → lane_valid=0 during the gap. 0x03 lands on lane 2. lane0=0x01 and lane1=0x02 hold through the gap.
- Realign with data: send 0x30,0x31,0x32 (ptr=3), then 0x55 with realign=1, then 0x56 → 0x55 on lane 0 and 0x56 on lane 1. Lane 3 is not written.
- No lane: lane_en=0, send 0xFF → lane_valid stays 0 and err_no_lane=1 for exactly one cycle. Then set lane_en=4'b0100 and send 0x77 → 0x77 lands on lane 2.
- Reset mid-stream: send 0x40,0x41, assert reset for 1 cycle coincident with 0x42 → after that edge, all lane_data, lane_valid and err_no_lane are 0. Next word 0x43 lands on lane 0.

Source files
------------

// File: rtl/byte_striping_n.sv
// byte_striping_n: round-robin word striper across LANES lanes with enable mask, realign and no-lane error
module byte_striping_n #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [LANES-1:0]        lane_en,
  input  logic                    realign,
  output logic [LANES*DATA_W-1:0] lane_data,
  output logic [LANES-1:0]        lane_valid,
  output logic                    err_no_lane
);
  localparam int PTR_W = $clog2(LANES);
  logic [PTR_W-1:0]        r_ptr;
  logic [LANES*DATA_W-1:0] r_data;
  logic [LANES-1:0]        r_valid;
  logic                    r_err;
  logic [PTR_W-1:0]        w_tgt;
  logic                    w_found;
  logic [PTR_W-1:0]        w_next;
  // first enabled lane at or above the base, scanning downward so the nearest offset wins
  always_comb begin
    w_found = 1'b0;
    w_tgt   = '0;
    for (int o = LANES - 1; o >= 0; o--) begin
      int idx;
      idx = (realign ? 0 : int'(r_ptr)) + o;
      idx = idx >= LANES ? idx - LANES : idx;
      if (lane_en[idx]) begin
        w_found = 1'b1;
        w_tgt   = PTR_W'(idx);
      end
    end
  end
  assign w_next = w_tgt == PTR_W'(LANES - 1) ? '0 : w_tgt + 1'b1;
  // registered lane outputs and raw-successor pointer update
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= '0;
      r_err   <= 1'b0;
      if (valid_in && w_found) begin
        r_data[w_tgt*DATA_W +: DATA_W] <= data_in;
        r_valid[w_tgt]                 <= 1'b1;
        r_ptr                          <= w_next;
      end else begin
        r_err <= valid_in;
        if (realign) r_ptr <= '0;
      end
    end
  end
  assign lane_data   = r_data;
  assign lane_valid  = r_valid;
  assign err_no_lane = r_err;
endmodule
